// File: rtl/pulpemu_stdout_buffer.sv
// ---------------------------------------------------------------------------
// pulpemu_stdout_buffer
//
// Collects the byte stream that PULP software writes to its emulated stdout.
// When the buffer must be drained (it becomes full, a newline is written, or
// a flush is requested) stdout_wait_o is raised towards the GPIO bridge and
// the producer stalls. The Zynq host reads count_o and the buffered bytes,
// then completes a four-phase handshake on stdout_flushed_i
// (raise -> buffer cleared, lower -> producer released).
//
// Handshake semantics on the producer side: a byte transfers on every rising
// clock edge where wr_valid_i and wr_ready_o are both 1. wr_ready_o depends
// only on the state register, so the producer may hold wr_valid_i/wr_data_i
// stable across stalled cycles without any combinational loop.
//
// Ports:
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   wr_valid_i        producer byte valid
//   wr_data_i[7:0]    producer byte
//   wr_ready_o        buffer accepts a byte this cycle (FILL state)
//   flush_req_i       single-cycle request to drain a partial buffer
//   stdout_wait_o     buffer holds data for the host (WAIT state)
//   stdout_flushed_i  host acknowledge, already registered in clk domain
//   rd_addr_i         host read address
//   rd_data_o[7:0]    registered byte at rd_addr_i
//   count_o           number of valid bytes, 0..DEPTH
// ---------------------------------------------------------------------------
module pulpemu_stdout_buffer #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid_i,
    input  logic [7:0]        wr_data_i,
    output logic              wr_ready_o,
    input  logic              flush_req_i,
    output logic              stdout_wait_o,
    input  logic              stdout_flushed_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic [ADDR_W:0]   count_o
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      NEWLINE    = 8'h0A;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   count_inc;
    logic              wr_acc;
    logic              trigger;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_data_q;

    // Outputs decoded from the state register only: glitch-free and free of
    // any combinational path from the inputs.
    assign wr_ready_o    = (state_q == ST_FILL);
    assign stdout_wait_o = (state_q == ST_WAIT);
    assign count_o       = count_q;
    assign rd_data_o     = rd_data_q;

    assign wr_acc    = wr_valid_i & wr_ready_o;
    assign count_inc = count_q + {{ADDR_W{1'b0}}, 1'b1};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        trigger = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (wr_acc) begin
                    count_d = count_inc;
                end
                // Flush looks at the post-write count, so a flush together
                // with the first byte into an empty buffer still drains it.
                trigger = (wr_acc && ((count_inc == FULL_COUNT) || (wr_data_i == NEWLINE)))
                       || (flush_req_i && (count_d != '0));
                if (trigger) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stdout_flushed_i) begin
                    state_d = ST_ACK;
                    count_d = '0;
                end
            end
            ST_ACK: begin
                if (!stdout_flushed_i) begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
                count_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and count registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one write port at index count, one synchronous read port.
    // count never exceeds DEPTH-1 while a write is accepted, so the low bits
    // are a valid index. Contents are deliberately not reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[count_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    // Non-blocking read of the array gives old data on a same-address
    // read/write collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

endmodule

// File: tb/tb_pulpemu_stdout_buffer.sv
module tb_pulpemu_stdout_buffer;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  localparam int ACCEPTING = 0;
  localparam int HOLDING   = 1;
  localparam int RELEASED  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush_req = 1'b0;
  logic          flushed = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_ready_o;
  logic          stdout_wait_o;
  logic [7:0]    rd_data_o;
  logic [AW:0]   count_o;

  pulpemu_stdout_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_valid_i       (wr_valid),
    .wr_data_i        (wr_data),
    .wr_ready_o       (wr_ready_o),
    .flush_req_i      (flush_req),
    .stdout_wait_o    (stdout_wait_o),
    .stdout_flushed_i (flushed),
    .rd_addr_i        (rd_addr),
    .rd_data_o        (rd_data_o),
    .count_o          (count_o)
  );

  int total = 0;
  int bad = 0;

  // ---------------- reference model ----------------
  // Buffer content as a byte queue; mode says who owns the buffer.
  logic [7:0] bq[$];
  logic [7:0] shadow[DEPTH];
  bit         known[DEPTH];
  int         mode = ACCEPTING;
  logic [AW:0] exp_count = '0;
  logic        exp_wait = 1'b0;
  logic        exp_ready = 1'b1;
  logic [7:0]  exp_rd = 8'h00;
  bit          exp_rd_known = 1'b1;

  task automatic model_reset();
    bq.delete();
    mode = ACCEPTING;
    exp_count = '0;
    exp_wait = 1'b0;
    exp_ready = 1'b1;
    exp_rd = 8'h00;
    exp_rd_known = 1'b1;
  endtask

  task automatic model_step();
    bit trig;
    exp_rd_known = known[rd_addr];
    exp_rd = shadow[rd_addr];
    trig = 1'b0;
    case (mode)
      ACCEPTING: begin
        if (wr_valid) begin
          shadow[bq.size()] = wr_data;
          known[bq.size()] = 1'b1;
          bq.push_back(wr_data);
          if (bq.size() == DEPTH || wr_data == 8'h0A) trig = 1'b1;
        end
        if (flush_req && bq.size() > 0) trig = 1'b1;
        if (trig) mode = HOLDING;
      end
      HOLDING: if (flushed) begin
        bq.delete();
        mode = RELEASED;
      end
      default: if (!flushed) mode = ACCEPTING;
    endcase
    exp_count = (AW + 1)'(bq.size());
    exp_wait = (mode == HOLDING);
    exp_ready = (mode == ACCEPTING);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_valid = 1'b0;
    flush_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (count_o !== 9'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (stdout_wait_o !== 1'b0) begin bad++; $display("FAIL reset_wait got=%b exp=0", stdout_wait_o); end
    total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wr_ready_o); end
    total++; if (rd_data_o !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", rd_data_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_line();
    logic [7:0] msg[3];
    msg = '{8'h68, 8'h69, 8'h0A};
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = msg[i];
      total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL hi_ready_%0d got=%b exp=1", i, wr_ready_o); end
      tick();
    end
    clear_inputs();
    total++; if (stdout_wait_o !== 1'b1) begin bad++; $display("FAIL hi_wait got=%b exp=1", stdout_wait_o); end
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL hi_stall got=%b exp=0", wr_ready_o); end
    total++; if (count_o !== 9'd3) begin bad++; $display("FAIL hi_count got=%0d exp=3", count_o); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = AW'(i);
      tick();
      total++; if (rd_data_o !== msg[i]) begin bad++; $display("FAIL hi_read_%0d got=%h exp=%h", i, rd_data_o, msg[i]); end
    end
    total++; if (count_o !== 9'd3) begin bad++; $display("FAIL hi_count_frozen got=%0d exp=3", count_o); end
    flushed = 1'b1;
    tick();
    total++; if (count_o !== 9'd0) begin bad++; $display("FAIL hi_ack_count got=%0d exp=0", count_o); end
    total++; if (stdout_wait_o !== 1'b0) begin bad++; $display("FAIL hi_ack_wait got=%b exp=0", stdout_wait_o); end
    total++; if (wr_ready_o !== 1'b0) begin bad++; $display("FAIL hi_ack_ready got=%b exp=0", wr_ready_o); end
    flushed = 1'b0;
    tick();
    total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL hi_release_ready got=%b exp=1", wr_ready_o); end
  endtask

  task automatic test_full_buffer();
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data = 8'($urandom_range(0, 255));
      if (wr_data == 8'h0A) wr_data = 8'h0B;
      tick();
      if (i < DEPTH - 1) begin
        total++; if (stdout_wait_o !== 1'b0) begin bad++; $display("FAIL full_early_wait_%0d got=%b exp=0", i, stdout_wait_o); end
      end
    end
    total++; if (count_o !== 9'd256) begin bad++; $display("FAIL full_count got=%0d exp=256", count_o); end
    total++; if (stdout_wait_o !== 1'b1) begin bad++; $display("FAIL full_wait got=%b exp=1", stdout_wait_o); end
    // Extra byte held on the bus: must stall until the handshake completes.
    wr_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (wr_ready_o !== 1'b0 || count_o !== 9'd256) begin
        bad++; $display("FAIL full_stall_%0d got=ready %b count %0d exp=ready 0 count 256", i, wr_ready_o, count_o);
      end
    end
    flushed = 1'b1;
    tick();
    total++; if (count_o !== 9'd0) begin bad++; $display("FAIL full_ack_count got=%0d exp=0", count_o); end
    flushed = 1'b0;
    tick();
    total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL full_release got=%b exp=1", wr_ready_o); end
    tick();
    total++; if (count_o !== 9'd1) begin bad++; $display("FAIL full_257_count got=%0d exp=1", count_o); end
    clear_inputs();
    rd_addr = '0;
    tick();
    total++; if (rd_data_o !== 8'h55) begin bad++; $display("FAIL full_257_data got=%h exp=55", rd_data_o); end
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    total++; if (stdout_wait_o !== 1'b1) begin bad++; $display("FAIL full_flush_wait got=%b exp=1", stdout_wait_o); end
    flushed = 1'b1; tick();
    flushed = 1'b0; tick();
  endtask

  task automatic test_flush();
    wr_valid = 1'b1; wr_data = 8'h41; tick();
    wr_data = 8'h42; tick();
    clear_inputs(); flush_req = 1'b1; tick();
    flush_req = 1'b0;
    total++; if (stdout_wait_o !== 1'b1 || count_o !== 9'd2) begin
      bad++; $display("FAIL flush_partial got=wait %b count %0d exp=wait 1 count 2", stdout_wait_o, count_o);
    end
    flushed = 1'b1; tick();
    flushed = 1'b0; tick();
    flush_req = 1'b1; tick();
    flush_req = 1'b0;
    total++; if (stdout_wait_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_empty got=wait %b ready %b exp=wait 0 ready 1", stdout_wait_o, wr_ready_o);
    end
    tick();
    total++; if (stdout_wait_o !== 1'b0) begin bad++; $display("FAIL flush_empty_stay got=%b exp=0", stdout_wait_o); end
    wr_valid = 1'b1; wr_data = 8'h43; flush_req = 1'b1; tick();
    clear_inputs();
    total++; if (stdout_wait_o !== 1'b1 || count_o !== 9'd1) begin
      bad++; $display("FAIL flush_with_write got=wait %b count %0d exp=wait 1 count 1", stdout_wait_o, count_o);
    end
    flushed = 1'b1; tick();
    flushed = 1'b0; tick();
  endtask

  task automatic test_handshake_order();
    flushed = 1'b1;
    tick();
    total++; if (wr_ready_o !== 1'b1 || stdout_wait_o !== 1'b0) begin
      bad++; $display("FAIL hs_fill_ignores got=ready %b wait %b exp=ready 1 wait 0", wr_ready_o, stdout_wait_o);
    end
    wr_valid = 1'b1; wr_data = 8'h0A; tick();
    clear_inputs();
    total++; if (stdout_wait_o !== 1'b1 || count_o !== 9'd1) begin
      bad++; $display("FAIL hs_trigger got=wait %b count %0d exp=wait 1 count 1", stdout_wait_o, count_o);
    end
    tick();
    total++; if (stdout_wait_o !== 1'b0 || count_o !== 9'd0 || wr_ready_o !== 1'b0) begin
      bad++; $display("FAIL hs_ack got=wait %b count %0d ready %b exp=wait 0 count 0 ready 0", stdout_wait_o, count_o, wr_ready_o);
    end
    wr_valid = 1'b1; wr_data = 8'h11; flush_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (count_o !== 9'd0 || wr_ready_o !== 1'b0 || stdout_wait_o !== 1'b0) begin
        bad++; $display("FAIL hs_ack_ignore_%0d got=count %0d ready %b wait %b exp=count 0 ready 0 wait 0", i, count_o, wr_ready_o, stdout_wait_o);
      end
    end
    clear_inputs(); flushed = 1'b0; tick();
    total++; if (wr_ready_o !== 1'b1 || count_o !== 9'd0) begin
      bad++; $display("FAIL hs_release got=ready %b count %0d exp=ready 1 count 0", wr_ready_o, count_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] msg[5];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0A};
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = msg[i]; tick();
    end
    clear_inputs();
    rd_addr = '0;
    tick();
    total++; if (stdout_wait_o !== 1'b1 || count_o !== 9'd5 || rd_data_o !== 8'h31) begin
      bad++; $display("FAIL rw_setup got=wait %b count %0d rd %h exp=wait 1 count 5 rd 31", stdout_wait_o, count_o, rd_data_o);
    end
    rst_n = 1'b0;
    #1;
    total++; if (stdout_wait_o !== 1'b0) begin bad++; $display("FAIL rw_async_wait got=%b exp=0", stdout_wait_o); end
    total++; if (count_o !== 9'd0) begin bad++; $display("FAIL rw_async_count got=%0d exp=0", count_o); end
    total++; if (rd_data_o !== 8'h00) begin bad++; $display("FAIL rw_async_rd got=%h exp=00", rd_data_o); end
    model_reset();
    flushed = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++; if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL rw_ready_after got=%b exp=1", wr_ready_o); end
    wr_valid = 1'b1; wr_data = 8'h61; tick();
    wr_data = 8'h62; tick();
    clear_inputs();
    total++; if (count_o !== 9'd2 || stdout_wait_o !== 1'b0) begin
      bad++; $display("FAIL rw_writes got=count %0d wait %b exp=count 2 wait 0", count_o, stdout_wait_o);
    end
    flushed = 1'b0;
    flush_req = 1'b1; tick();
    flush_req = 1'b0;
    flushed = 1'b1; tick();
    flushed = 1'b0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data = ($urandom_range(0, 39) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
      flush_req = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 5) == 0) flushed = ~flushed;
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      tick();
      total++; if (count_o !== exp_count) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count_o, exp_count); end
      total++; if (stdout_wait_o !== exp_wait) begin bad++; $display("FAIL rnd_wait cyc=%0d got=%b exp=%b", c, stdout_wait_o, exp_wait); end
      total++; if (wr_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, wr_ready_o, exp_ready); end
      if (exp_rd_known) begin
        total++; if (rd_data_o !== exp_rd) begin bad++; $display("FAIL rnd_rd cyc=%0d got=%h exp=%h", c, rd_data_o, exp_rd); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_full_buffer();
    test_flush();
    test_handshake_order();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
